// File: rtl/sample_dispatcher.sv
// Front-end controller for the tree-inference pipeline: buffers samples, injects one per
// cycle into stage 1, sequences threshold loads and captures tagged leaf decisions.
module sample_dispatcher #(
  parameter int PIPE_LATENCY = 38,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_last,
  input  logic [2:0]   cfg_stage,
  input  logic [7:0]   cfg_node,
  input  logic [31:0]  cfg_data,
  input  logic         run_start,
  input  logic         run_stop,
  output logic         state,
  output logic [7:0]   thresStageSel,
  output logic [7:0]   thresNodeIndex,
  output logic [31:0]  thresData,
  output logic [255:0] sampleData_o,
  output logic         nodeIndexOut,
  input  logic [255:0] decision_i,
  output logic         res_valid,
  output logic [255:0] res_data,
  output logic         busy,
  output logic [15:0]  issued_cnt,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid must not depend on ready. Results have no ready and must always be taken.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [255:0]            mem_q [FIFO_DEPTH];
  logic [PIPE_LATENCY-1:0] tag_q, tag_d;
  logic                    issue_vld_q, issue_vld_d;
  logic [255:0]            sample_q, sample_d;
  logic                    res_valid_q, res_valid_d;
  logic [255:0]            res_data_q, res_data_d;
  logic                    wr_en_q, wr_en_d;
  logic [7:0]              sel_q, sel_d;
  logic [7:0]              node_q, node_d;
  logic [31:0]             tdata_q, tdata_d;
  logic [15:0]             cnt_q, cnt_d;

  logic full, empty, push, pop, cfg_rdy, cfg_acc, drain_clear;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign cfg_acc = cfg_valid && cfg_rdy;

  // The issue register is the head of the tag line, so DRAIN may leave once nothing
  // will remain in flight after this edge.
  assign drain_clear = (tag_q[PIPE_LATENCY-2:0] == '0) && !issue_vld_q;

  always_comb begin
    fsm_d   = fsm_q;
    cfg_rdy = 1'b0;
    pop     = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        cfg_rdy = 1'b1;
        if (cfg_valid) begin
          fsm_d = cfg_last ? S_IDLE : S_LOAD;
        end else if (run_start) begin
          fsm_d = S_RUN;
        end
      end
      S_LOAD: begin
        cfg_rdy = 1'b1;
        if (cfg_valid && cfg_last) begin
          fsm_d = S_IDLE;
        end
      end
      S_RUN: begin
        pop = !empty && !run_stop;
        if (run_stop) begin
          fsm_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_clear) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    sample_d    = pop ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    issue_vld_d = pop;
    cnt_d       = cnt_q + {15'd0, pop};
    tag_d       = {tag_q[PIPE_LATENCY-2:0], issue_vld_q};
    res_valid_d = tag_q[PIPE_LATENCY-1];
    res_data_d  = tag_q[PIPE_LATENCY-1] ? decision_i : res_data_q;
    wr_en_d     = cfg_acc;
    sel_d       = cfg_acc ? (8'd1 << cfg_stage) : 8'd0;
    node_d      = cfg_acc ? cfg_node : node_q;
    tdata_d     = cfg_acc ? cfg_data : tdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      issue_vld_q <= 1'b0;
      sample_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      wr_en_q     <= 1'b0;
      sel_q       <= '0;
      node_q      <= '0;
      tdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
      issue_vld_q <= issue_vld_d;
      sample_q    <= sample_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      wr_en_q     <= wr_en_d;
      sel_q       <= sel_d;
      node_q      <= node_d;
      tdata_q     <= tdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage needs no reset: only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  assign in_ready       = !full;
  assign cfg_ready      = cfg_rdy;
  assign state          = wr_en_q;
  assign thresStageSel  = sel_q;
  assign thresNodeIndex = node_q;
  assign thresData      = tdata_q;
  assign sampleData_o   = sample_q;
  assign nodeIndexOut   = 1'b0;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign busy           = (fsm_q != S_IDLE) || (tag_q != '0) || issue_vld_q;
  assign issued_cnt     = cnt_q;
  assign dbg_state      = fsm_q;

endmodule
